exp_normalize_stage: RTL and testbench

- Softmax output stage, directly downstream of the subtract block.
- Consumes the log-domain difference d = x − ln(Σe^x), one sample per handshake, and emits e^d as the normalized probability.
- Computes e^d as 2^(d·log2e): 3-stage pipeline (multiply → split/LUT → shift), valid/ready flow control, `last` propagation.
- Counts samples per vector and flags framing errors.

---
 rtl/softmax_pkg.sv | 31 +++
 rtl/exp2_frac_lut.sv | 82 ++++++++
 rtl/exp_normalize_stage.sv | 131 +++++++++++++
 tb/tb_exp_normalize_stage.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/softmax_pkg.sv
// Shared types and fixed-point constants for the softmax output path.
// Holds the Q5.10 / Q1.15 formats, log2(e) and the pipeline payload structs.
package softmax_pkg;

    localparam int Q5_10_W    = 16;
    localparam int Q5_10_FRAC = 10;
    localparam int Q1_15_W    = 16;
    localparam int Q1_15_FRAC = 15;

    // log2(e) in unsigned Q1.15
    localparam logic [15:0] LOG2E_Q15 = 16'hB8AA;
    // 1.0 in unsigned Q1.15
    localparam logic [15:0] ONE_Q15   = 16'h8000;

    // Q5.10 x Q1.15 product, signed, plus the magnitude that -p needs
    localparam int PROD_W = 33;
    localparam int MAG_W  = 31;

    typedef struct packed {
        logic                     clamp;
        logic                     last;
        logic signed [PROD_W-1:0] prod;
    } s1_t;

    typedef struct packed {
        logic                 clamp;
        logic                 last;
        logic [Q1_15_W-1:0]   lut;
    } s2_t;

endpackage

// File: rtl/exp2_frac_lut.sv
// Combinational ROM of 2^(-k/64) in unsigned Q1.15, rounded to nearest.
// Ports: idx (table index, LUT_BITS wide) -> val (Q1.15 mantissa).
module exp2_frac_lut #(
    parameter int LUT_BITS = 6
) (
    input  logic [LUT_BITS-1:0] idx,
    output logic [15:0]         val
);

    // Entry k = round(32768 * 2^(-k/64)); 64 entries for a 6-bit index.
    always_comb begin
        val = 16'd0;
        case (idx)
            6'd0:  val = 16'd32768;
            6'd1:  val = 16'd32415;
            6'd2:  val = 16'd32066;
            6'd3:  val = 16'd31720;
            6'd4:  val = 16'd31379;
            6'd5:  val = 16'd31041;
            6'd6:  val = 16'd30706;
            6'd7:  val = 16'd30376;
            6'd8:  val = 16'd30048;
            6'd9:  val = 16'd29725;
            6'd10: val = 16'd29405;
            6'd11: val = 16'd29088;
            6'd12: val = 16'd28774;
            6'd13: val = 16'd28464;
            6'd14: val = 16'd28158;
            6'd15: val = 16'd27855;
            6'd16: val = 16'd27554;
            6'd17: val = 16'd27258;
            6'd18: val = 16'd26964;
            6'd19: val = 16'd26674;
            6'd20: val = 16'd26386;
            6'd21: val = 16'd26102;
            6'd22: val = 16'd25821;
            6'd23: val = 16'd25543;
            6'd24: val = 16'd25268;
            6'd25: val = 16'd24995;
            6'd26: val = 16'd24726;
            6'd27: val = 16'd24460;
            6'd28: val = 16'd24196;
            6'd29: val = 16'd23936;
            6'd30: val = 16'd23678;
            6'd31: val = 16'd23423;
            6'd32: val = 16'd23170;
            6'd33: val = 16'd22921;
            6'd34: val = 16'd22674;
            6'd35: val = 16'd22430;
            6'd36: val = 16'd22188;
            6'd37: val = 16'd21949;
            6'd38: val = 16'd21713;
            6'd39: val = 16'd21479;
            6'd40: val = 16'd21247;
            6'd41: val = 16'd21019;
            6'd42: val = 16'd20792;
            6'd43: val = 16'd20568;
            6'd44: val = 16'd20347;
            6'd45: val = 16'd20127;
            6'd46: val = 16'd19911;
            6'd47: val = 16'd19696;
            6'd48: val = 16'd19484;
            6'd49: val = 16'd19274;
            6'd50: val = 16'd19066;
            6'd51: val = 16'd18861;
            6'd52: val = 16'd18658;
            6'd53: val = 16'd18457;
            6'd54: val = 16'd18258;
            6'd55: val = 16'd18061;
            6'd56: val = 16'd17867;
            6'd57: val = 16'd17674;
            6'd58: val = 16'd17484;
            6'd59: val = 16'd17296;
            6'd60: val = 16'd17109;
            6'd61: val = 16'd16925;
            6'd62: val = 16'd16743;
            6'd63: val = 16'd16562;
            default: val = 16'd0;
        endcase
    end

endmodule

// File: rtl/exp_normalize_stage.sv
// Softmax output stage: e^d = 2^(d*log2e) over a 3-stage valid/ready pipe.
// Ports: clk, rst_n (sync, active-high), data_i/data_valid_i/last_i/ready_o
// upstream; data_o/data_valid_o/last_o/ready_i downstream; err_o framing.
module exp_normalize_stage
    import softmax_pkg::*;
#(
    parameter int CNT_MAX   = 8,
    parameter int FRAC_BITS = 10,
    parameter int LUT_BITS  = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] data_i,
    input  logic        data_valid_i,
    input  logic        last_i,
    output logic        ready_o,
    output logic [15:0] data_o,
    output logic        data_valid_o,
    output logic        last_o,
    input  logic        ready_i,
    output logic        err_o
);

    localparam int CNT_W  = $clog2(CNT_MAX);
    localparam int P_FRAC = FRAC_BITS + Q1_15_FRAC;
    localparam int SH_W   = MAG_W - P_FRAC;
    localparam int EXT_W  = PROD_W - 16;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);
    localparam logic [SH_W-1:0]  SH_ZERO  = SH_W'(16);

    logic                     adv;
    logic                     in_xfer;
    logic                     v1;
    logic                     v2;
    s1_t                      s1_d;
    s1_t                      s1_q;
    s2_t                      s2_q;
    logic [SH_W-1:0]          sh_q;
    logic signed [PROD_W-1:0] neg_p;
    logic [MAG_W-1:0]         mag;
    logic [LUT_BITS-1:0]      idx;
    logic [15:0]              lut_val;
    logic [15:0]              scaled;
    logic [CNT_W-1:0]         cnt_q;
    logic                     at_end;
    logic                     unused_hi;

    // Whole pipe moves as one; ready_i reaches ready_o combinationally.
    assign adv     = ready_i | ~data_valid_o;
    assign ready_o = adv;
    assign in_xfer = data_valid_i & adv;

    // S1: p in units of 2^-25. A non-negative d is illegal upstream,
    // so it is pinned to 1.0 instead of letting 2^p overflow.
    always_comb begin
        s1_d.clamp = ~data_i[15];
        s1_d.last  = last_i & data_valid_i;
        s1_d.prod  = $signed({{EXT_W{data_i[15]}}, data_i})
                   * $signed({{EXT_W{1'b0}}, LOG2E_Q15});
    end

    // S2: split |p| into integer shift and fractional table index.
    // The 31-bit magnitude still holds d = -32.0.
    assign neg_p     = -s1_q.prod;
    assign mag       = neg_p[MAG_W-1:0];
    assign unused_hi = ^neg_p[PROD_W-1:MAG_W];
    assign idx       = mag[P_FRAC-1 -: LUT_BITS];

    exp2_frac_lut #(
        .LUT_BITS (LUT_BITS)
    ) u_lut (
        .idx (idx),
        .val (lut_val)
    );

    // S3: 2^-n scaling; a shift of 16 or more underflows to zero.
    assign scaled = (sh_q >= SH_ZERO) ? 16'd0 : (s2_q.lut >> sh_q);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            v1           <= 1'b0;
            v2           <= 1'b0;
            data_valid_o <= 1'b0;
            s1_q         <= '0;
            s2_q         <= '0;
            sh_q         <= '0;
            data_o       <= '0;
            last_o       <= 1'b0;
        end else if (adv) begin
            v1           <= in_xfer;
            s1_q         <= s1_d;
            v2           <= v1;
            s2_q.clamp   <= s1_q.clamp;
            s2_q.last    <= s1_q.last;
            s2_q.lut     <= lut_val;
            sh_q         <= mag[MAG_W-1:P_FRAC];
            data_valid_o <= v2;
            data_o       <= s2_q.clamp ? ONE_Q15 : scaled;
            last_o       <= s2_q.last;
        end
    end

    // Framing: a vector is exactly CNT_MAX samples ending in last.
    assign at_end = (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            cnt_q <= '0;
            err_o <= 1'b0;
        end else if (in_xfer) begin
            unique case (1'b1)
                (last_i & at_end): begin
                    cnt_q <= '0;
                end
                (last_i & ~at_end): begin
                    cnt_q <= '0;
                    err_o <= 1'b1;
                end
                (~last_i & at_end): begin
                    cnt_q <= '0;
                    err_o <= 1'b1;
                end
                default: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exp_normalize_stage.sv
// Directed bench for exp_normalize_stage with hand-computed e^d values.
// A negedge monitor checks every output against a queue of expectations.
module tb_exp_normalize_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] data_i = 16'd0;
    logic        data_valid_i = 1'b0;
    logic        last_i = 1'b0;
    logic        ready_o;
    logic [15:0] data_o;
    logic        data_valid_o;
    logic        last_o;
    logic        ready_i = 1'b1;
    logic        err_o;

    logic        tog_en = 1'b0;
    int          n_chk = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          t_in = 0;
    int          out_cnt = 0;
    logic [16:0] exp_q[$];

    exp_normalize_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_i       (data_i),
        .data_valid_i (data_valid_i),
        .last_i       (last_i),
        .ready_o      (ready_o),
        .data_o       (data_o),
        .data_valid_o (data_valid_o),
        .last_o       (last_o),
        .ready_i      (ready_i),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        ready_i = tog_en ? ~ready_i : 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("ready_o", {31'd0, ready_o}, {31'd0, ready_i | ~data_valid_o});
            if (data_valid_o) begin
                if (exp_q.size() == 0) begin
                    chk("spurious", 1, 0);
                end else begin
                    chk(ready_i ? "data" : "hold", {16'd0, data_o},
                        {16'd0, exp_q[0][15:0]});
                    chk("last", {31'd0, last_o}, {31'd0, exp_q[0][16]});
                    if (ready_i) begin
                        void'(exp_q.pop_front());
                        out_cnt++;
                    end
                end
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d, input logic l,
                        input logic [15:0] e);
        logic got;
        got = 1'b0;
        data_i = d;
        last_i = l;
        data_valid_i = 1'b1;
        exp_q.push_back({l, e});
        for (int k = 0; k < 64 && !got; k++) begin
            @(negedge clk);
            got = ready_o;
            sync();
        end
        if (!got) chk("send_timeout", 0, 1);
        data_valid_i = 1'b0;
        last_i = 1'b0;
        t_in = cyc;
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && exp_q.size() != 0; k++)
            @(negedge clk);
        chk("drain", exp_q.size(), 0);
        sync();
    endtask

    task automatic latency_check();
        int lat;
        lat = -1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (data_valid_o) begin
                lat = cyc - t_in + 1;
                break;
            end
        end
        chk("latency", lat, 3);
        @(negedge clk);
        chk("vpulse", {31'd0, data_valid_o}, 0);
        sync();
    endtask

    logic [15:0] dv[7] = '{16'hFD3A, 16'hFC00, 16'hC000, 16'h8000,
                           16'h0100, 16'hFE00, 16'hFFFF};
    logic [15:0] ev[7] = '{16'h4000, 16'h2F42, 16'h0000, 16'h0000,
                           16'h8000, 16'h4DC7, 16'h8000};
    logic [15:0] sv[8] = '{16'hFD3A, 16'hFC00, 16'hFE00, 16'hFFFF,
                           16'hC000, 16'hF800, 16'hFF00, 16'h8000};
    logic [15:0] se[8] = '{16'h4000, 16'h2F42, 16'h4DC7, 16'h8000,
                           16'h0000, 16'h1172, 16'h63C7, 16'h0000};

    initial begin
        int o0;
        logic seen;

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        chk("rst_valid", {31'd0, data_valid_o}, 0);
        chk("rst_data", {16'd0, data_o}, 0);
        chk("rst_last", {31'd0, last_o}, 0);
        chk("rst_err", {31'd0, err_o}, 0);
        chk("rst_ready", {31'd0, ready_o}, 1);

        send(16'h0000, 1'b0, 16'h8000);
        latency_check();

        for (int i = 0; i < 7; i++)
            send(dv[i], i == 6, ev[i]);
        drain();
        chk("err_vec", {31'd0, err_o}, 0);

        o0 = out_cnt;
        for (int i = 0; i < 8; i++)
            send(sv[i], i == 7, se[i]);
        drain();
        chk("n_stream", out_cnt - o0, 8);
        chk("err_stream", {31'd0, err_o}, 0);

        tog_en = 1'b1;
        o0 = out_cnt;
        for (int i = 0; i < 8; i++)
            send(sv[i], i == 7, se[i]);
        drain();
        tog_en = 1'b0;
        sync();
        chk("n_stall", out_cnt - o0, 8);
        chk("err_stall", {31'd0, err_o}, 0);

        for (int i = 0; i < 5; i++) begin
            send(16'hFC00, i == 4, 16'h2F42);
            if (i == 3) chk("err_pre", {31'd0, err_o}, 0);
        end
        chk("err_short", {31'd0, err_o}, 1);
        chk("cnt_short", {29'd0, dut.cnt_q}, 0);
        for (int i = 0; i < 9; i++) begin
            send(16'hFC00, 1'b0, 16'h2F42);
            if (i == 7) chk("cnt_wrap", {29'd0, dut.cnt_q}, 0);
        end
        chk("cnt_after", {29'd0, dut.cnt_q}, 1);
        chk("err_sticky", {31'd0, err_o}, 1);
        drain();

        send(16'hFC00, 1'b0, 16'h2F42);
        send(16'hFD3A, 1'b0, 16'h4000);
        rst_n = 1'b1;
        exp_q.delete();
        sync();
        rst_n = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (data_valid_o) seen = 1'b1;
        end
        chk("flush", {31'd0, seen}, 0);
        chk("err_clr", {31'd0, err_o}, 0);
        chk("cnt_clr", {29'd0, dut.cnt_q}, 0);
        sync();

        send(16'h0000, 1'b0, 16'h8000);
        latency_check();
        drain();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
